if_stage_ibuf: RTL



---
 rtl/if_stage_ibuf.sv | 109 ++++++++++
 1 files changed

// File: rtl/if_stage_ibuf.sv
// rtl/if_stage_ibuf.sv - fetch stage with split inst bus and in-order instruction buffer
// Optional IBUF_BYPASS_EN: forward a response straight to decode when the buffer head is waiting on it.
module if_stage_ibuf #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);
  localparam int AW = $clog2(IBUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);

  logic        br_taken;
  logic [31:0] br_target;
  assign {br_taken, br_target} = br_bus;

  logic [31:0]           fetch_pc;
  logic [31:0]           slot_pc   [IBUF_DEPTH];
  logic [31:0]           slot_inst [IBUF_DEPTH];
  logic [IBUF_DEPTH-1:0] slot_alloc;
  logic [IBUF_DEPTH-1:0] slot_filled;
  logic [AW-1:0]         head, fill, tail;
  logic [CW-1:0]         alloc_cnt, pending, discard;
  logic [CW:0]           outstanding;
  logic                  hs, pop, take_data, head_ready, bypass, write_slot;

  // pending counts current-path requests in flight; discard counts old-path ones.
  assign outstanding = {1'b0, pending} + {1'b0, discard};
  assign inst_addr   = br_taken ? br_target : fetch_pc;
  assign inst_req    = !reset && (outstanding < {1'b0, DEPTH_C})
                       && (br_taken || alloc_cnt < DEPTH_C);
  assign hs          = inst_req && inst_addr_ok;
  assign take_data   = inst_data_ok && discard == '0 && !br_taken;

`ifdef IBUF_BYPASS_EN
  assign bypass = take_data && slot_alloc[head] && !slot_filled[head] && head == fill;
`else
  assign bypass = 1'b0;
`endif

  assign head_ready     = slot_alloc[head] && slot_filled[head] && !br_taken;
  assign fs_to_ds_valid = head_ready || bypass;
  assign fs_to_ds_bus   = {bypass ? inst_rdata : slot_inst[head], slot_pc[head]};
  assign pop            = fs_to_ds_valid && ds_allowin;
  // A bypassed response consumed by decode this cycle never lands in the buffer.
  assign write_slot     = take_data && !(bypass && ds_allowin);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      head        <= '0;
      fill        <= '0;
      tail        <= '0;
      alloc_cnt   <= '0;
      pending     <= '0;
      discard     <= '0;
      slot_alloc  <= '0;
      slot_filled <= '0;
    end else if (br_taken) begin
      head        <= '0;
      fill        <= '0;
      tail        <= hs ? AW'(1) : '0;
      alloc_cnt   <= hs ? CW'(1) : '0;
      pending     <= hs ? CW'(1) : '0;
      discard     <= discard + pending - CW'(inst_data_ok);
      slot_alloc  <= hs ? IBUF_DEPTH'(1) : '0;
      slot_filled <= '0;
      fetch_pc    <= hs ? inst_addr + 32'd4 : br_target;
    end else begin
      if (hs) begin
        slot_alloc[tail] <= 1'b1;
        tail             <= tail + AW'(1);
        fetch_pc         <= inst_addr + 32'd4;
      end
      if (inst_data_ok && discard != '0)
        discard <= discard - CW'(1);
      if (take_data)
        fill <= fill + AW'(1);
      if (write_slot)
        slot_filled[fill] <= 1'b1;
      if (pop) begin
        slot_alloc[head]  <= 1'b0;
        slot_filled[head] <= 1'b0;
        head              <= head + AW'(1);
      end
      pending   <= pending + CW'(hs) - CW'(take_data);
      alloc_cnt <= alloc_cnt + CW'(hs) - CW'(pop);
    end
  end

  // Payload storage needs no reset; validity lives in slot_alloc/slot_filled.
  always_ff @(posedge clk) begin
    if (hs)
      slot_pc[br_taken ? '0 : tail] <= inst_addr;
    if (write_slot)
      slot_inst[fill] <= inst_rdata;
  end

endmodule
